// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Optional U/J support is selected with the INST_ENCODER_UJ_EN macro (see imm_range_chk).
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    typedef struct packed {
        fmt_e               fmt;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic signed [31:0] imm;
    } enc_req_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;

endpackage

// File: rtl/inst_encoder_imm_range_chk.sv
// Flags immediates that the selected instruction format cannot represent.
// U and J are legal only when INST_ENCODER_UJ_EN is defined.
module imm_range_chk
    import inst_enc_pkg::*;
(
    input  fmt_e               fmt,
    input  logic signed [31:0] imm,
    output logic               err
);

    always_comb begin
        err = 1'b1;
        case (fmt)
            FMT_I, FMT_S: err = (imm < -32'sd2048) || (imm > 32'sd2047);
            FMT_B:        err = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
`ifdef INST_ENCODER_UJ_EN
            FMT_U:        err = |imm[11:0];
            FMT_J:        err = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
`endif
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: S1 registers fields and range-checks, S2 packs.
// U/J encoding is enabled by defining INST_ENCODER_UJ_EN; otherwise they produce the NOP with out_err.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic               out_err,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);

    enc_req_t    req_in;
    enc_req_t    req_p1;
    logic        vld_p1;
    logic        err_in;
    logic        err_p1;
    logic        s1_load;
    logic        s2_load;
    logic [31:0] word_p1;
    logic        unused_f7;

    assign req_in = '{fmt:    fmt_e'(in_fmt),
                      opcode: in_opcode,
                      rd:     in_rd,
                      rs1:    in_rs1,
                      rs2:    in_rs2,
                      funct3: in_funct3,
                      funct7: in_funct7,
                      imm:    in_imm};

    // funct7 is carried for a future R-type path but no supported format packs it
    assign unused_f7 = ^req_p1.funct7;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !vld_p1 || s2_load;
    assign in_ready = s1_load;

    imm_range_chk u_chk (
        .fmt (req_in.fmt),
        .imm (req_in.imm),
        .err (err_in)
    );

    always_comb begin
        word_p1 = NOP_INST;
        case (req_p1.fmt)
            FMT_I: word_p1 = {req_p1.imm[11:0], req_p1.rs1, req_p1.funct3, req_p1.rd, req_p1.opcode};
            FMT_S: word_p1 = {req_p1.imm[11:5], req_p1.rs2, req_p1.rs1, req_p1.funct3,
                              req_p1.imm[4:0], req_p1.opcode};
            FMT_B: word_p1 = {req_p1.imm[12], req_p1.imm[10:5], req_p1.rs2, req_p1.rs1,
                              req_p1.funct3, req_p1.imm[4:1], req_p1.imm[11], req_p1.opcode};
            FMT_U: word_p1 = {req_p1.imm[31:12], req_p1.rd, req_p1.opcode};
            FMT_J: word_p1 = {req_p1.imm[20], req_p1.imm[10:1], req_p1.imm[11],
                              req_p1.imm[19:12], req_p1.rd, req_p1.opcode};
            default: word_p1 = NOP_INST;
        endcase
        if (err_p1) word_p1 = NOP_INST;
    end

    // S1: capture request fields and the range-check verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            req_p1 <= '0;
            err_p1 <= 1'b0;
        end else if (s1_load) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                req_p1 <= req_in;
                err_p1 <= err_in;
            end
        end
    end

    // S2: packed word held stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_inst <= word_p1;
                out_err  <= err_p1;
            end
        end
    end

    // Output handshake counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            enc_count <= enc_count + COUNT_W'(1);
            if (out_err) err_count <= err_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodings, range errors, backpressure and reset.
module tb_inst_encoder;
    import inst_enc_pkg::*;

    localparam int COUNT_W = 16;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_fmt;
    logic [6:0]         in_opcode;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic [31:0]        in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic               out_err;
    logic [COUNT_W-1:0] enc_count;
    logic [COUNT_W-1:0] err_count;

    inst_encoder #(.COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_enc = 0;
    int          exp_err = 0;
    int          accepted = 0;
    logic [32:0] sb_q[$];
    logic [32:0] mon_e;

`ifdef INST_ENCODER_UJ_EN
    localparam logic [32:0] EXP_U = {1'b0, 32'h1234_52B7};
    localparam logic [32:0] EXP_J = {1'b0, 32'h0010_00EF};
`else
    localparam logic [32:0] EXP_U = {1'b1, 32'h0000_0013};
    localparam logic [32:0] EXP_J = {1'b1, 32'h0000_0013};
`endif
    localparam logic [32:0] EXP_NOP = {1'b1, 32'h0000_0013};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_inst", out_inst, mon_e[31:0]);
                check("out_err", {31'b0, out_err}, {31'b0, mon_e[32]});
                exp_enc++;
                if (mon_e[32]) exp_err++;
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, input logic [32:0] exp);
        int t;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = 7'h5a;
        in_imm    = imm;
        in_valid  = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                check("send_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        sb_q.push_back(exp);
        accepted++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_enc_count", enc_count, 32'd0);
        check("rst_err_count", err_count, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // I-type with latency measurement
        send(3'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 32'd1, {1'b0, 32'h0010_0093});
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", n, 32'd2);
        check("i_word", out_inst, 32'h0010_0093);
        drain();

        send(3'd1, STORE,  5'd0, 5'd2, 5'd1, 3'b010, 32'd3, {1'b0, 32'h0011_21A3});
        send(3'd2, BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8, {1'b0, 32'h0020_8463});
        send(3'd2, BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 32'd3, EXP_NOP);
        drain();
        check("err_count_b3", err_count, 32'd1);

        send(3'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048, EXP_NOP);
        send(3'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, -32'sd2048, {1'b0, 32'h8000_0093});
        send(3'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2047, {1'b0, 32'h7FF0_0093});
        send(3'd2, BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 32'd4094, {1'b0, 32'h7E20_8FE3});
        send(3'd2, BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, -32'sd4096, {1'b0, 32'h8020_8063});
        send(3'd2, BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 32'd4096, EXP_NOP);
        send(3'd5, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0, EXP_NOP);
        send(3'd3, LUI, 5'd5, 5'd0, 5'd0, 3'b000, 32'h1234_5000, EXP_U);
        send(3'd3, LUI, 5'd5, 5'd0, 5'd0, 3'b000, 32'h1234_5001, EXP_NOP);
        send(3'd4, JAL, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048, EXP_J);
        send(3'd4, JAL, 5'd1, 5'd0, 5'd0, 3'b000, 32'd3, EXP_NOP);
        drain();
        check("enc_count_tally", enc_count, exp_enc);
        check("err_count_tally", err_count, exp_err);

        // Backpressure: four back-to-back requests against a stalled consumer
        base = exp_enc;
        accepted = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(3'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, i, {1'b0, (32'(i) << 20) | 32'h93});
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", accepted, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_word", out_inst, 32'h0010_0093);
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_enc_delta", enc_count - COUNT_W'(base), 32'd4);

        // Reset with two words in flight
        out_ready = 1'b0;
        send(3'd0, OP_IMM, 5'd2, 5'd0, 5'd0, 3'b000, 32'd5, {1'b0, 32'h0050_0113});
        send(3'd0, OP_IMM, 5'd2, 5'd0, 5'd0, 3'b000, 32'd6, {1'b0, 32'h0060_0113});
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_enc_count", enc_count, 32'd0);
        check("mid_rst_err_count", err_count, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        sb_q.delete();
        exp_enc = 0;
        exp_err = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(3'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 32'd7, {1'b0, 32'h0070_0093});
        drain();
        check("post_rst_enc_count", enc_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
